// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: EX-stage op
// encodings, the controller state enum, and small op-decode helpers.
package muldiv_issue_ctrl_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MUL   = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Issue/sequencing controller for the HI/LO multiply and divide cores: accepts
// EX-stage ops, pulses core starts, times the result and stalls HI/LO readers.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 33
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    input  logic       rd_req,
    input  logic       flush,
    output logic       req_ready,
    output logic       stall,
    output logic       mul_start,
    output logic       div_start,
    output logic       core_sign,
    output logic [1:0] hilo_we,
    output logic       res_sel,
    output logic       busy,
    output logic       wb_valid
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             res_sel_nxt;
    logic             pend, pend_nxt;
    logic             done;
    logic             accept;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state   <= IDLE;
            cnt     <= '0;
            res_sel <= 1'b0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            res_sel <= res_sel_nxt;
            pend    <= pend_nxt;
        end
    end

    always_comb begin
        done      = (state != IDLE) && (cnt == '0);
        req_ready = (state == IDLE) || done;
        // Clr masks every pulse so a reset cycle can never launch work.
        accept    = !Clr && req_valid && req_ready && !flush && (req_op != OP_NOP);
        mul_start = accept && is_mul_op(req_op);
        div_start = accept && is_div_op(req_op);
        core_sign = is_signed_op(req_op);
        hilo_we   = 2'b00;
        if (accept && (req_op == OP_MTHI)) hilo_we = 2'b10;
        if (accept && (req_op == OP_MTLO)) hilo_we = 2'b01;
        busy      = !Clr && (state != IDLE) && !done;
        stall     = busy && (req_valid || rd_req);
        wb_valid  = !Clr && done && pend;

        state_nxt   = state;
        cnt_nxt     = cnt;
        res_sel_nxt = res_sel;
        pend_nxt    = pend;

        if (state != IDLE) begin
            if (done) state_nxt = IDLE;
            else      cnt_nxt   = cnt - 1'b1;
        end

        // A flushed MUL still finishes in the core, but must not write the GPR.
        if (done || flush) pend_nxt = 1'b0;

        if (mul_start) begin
            state_nxt   = MUL_RUN;
            cnt_nxt     = MUL_CNT;
            res_sel_nxt = 1'b1;
            pend_nxt    = (req_op == OP_MUL);
        end else if (div_start) begin
            state_nxt   = DIV_RUN;
            cnt_nxt     = DIV_CNT;
            res_sel_nxt = 1'b0;
            pend_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed timing scenarios plus randomized
// traffic, checked every cycle against a completion-time model.
module tb_muldiv_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic       rd_req = 1'b0;
    logic       flush = 1'b0;
    logic       req_ready, stall, mul_start, div_start, core_sign;
    logic [1:0] hilo_we;
    logic       res_sel, busy, wb_valid;

    muldiv_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .Clk(clk), .Clr(clr), .req_valid(req_valid), .req_op(req_op),
        .rd_req(rd_req), .flush(flush), .req_ready(req_ready), .stall(stall),
        .mul_start(mul_start), .div_start(div_start), .core_sign(core_sign),
        .hilo_we(hilo_we), .res_sel(res_sel), .busy(busy), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: an op in flight is just "finishes at cycle N".
    bit     chk_en = 1'b0;
    bit     m_active = 1'b0;
    longint m_done_at = 0;
    bit     m_res_sel = 1'b0;
    bit     m_pend = 1'b0;
    longint cyc = 0;

    always @(negedge clk) begin : model
        bit m_done, m_ready, m_acc, m_mul, m_div, m_busy;
        logic [1:0] m_we;
        int op;
        op      = int'(req_op);
        m_done  = m_active && (cyc == m_done_at);
        m_ready = !m_active || m_done;
        m_acc   = !clr && req_valid && m_ready && !flush && (op != 0);
        m_mul   = m_acc && (op == 1 || op == 2 || op == 5);
        m_div   = m_acc && (op == 3 || op == 4);
        m_we    = (m_acc && op == 6) ? 2'b10 : (m_acc && op == 7) ? 2'b01 : 2'b00;
        m_busy  = !clr && m_active && !m_done;
        if (chk_en) begin
            chk("req_ready", 8'(req_ready), 8'(m_ready));
            chk("mul_start", 8'(mul_start), 8'(m_mul));
            chk("div_start", 8'(div_start), 8'(m_div));
            chk("core_sign", 8'(core_sign), 8'(op == 1 || op == 3 || op == 5));
            chk("hilo_we", 8'(hilo_we), 8'(m_we));
            chk("res_sel", 8'(res_sel), 8'(m_res_sel));
            chk("busy", 8'(busy), 8'(m_busy));
            chk("stall", 8'(stall), 8'(m_busy && (req_valid || rd_req)));
            chk("wb_valid", 8'(wb_valid), 8'(!clr && m_done && m_pend));
        end
        if (clr) begin
            m_active  = 1'b0;
            m_res_sel = 1'b0;
            m_pend    = 1'b0;
        end else if (m_mul) begin
            m_active  = 1'b1;
            m_done_at = cyc + MUL_LAT;
            m_res_sel = 1'b1;
            m_pend    = (op == 5);
        end else if (m_div) begin
            m_active  = 1'b1;
            m_done_at = cyc + DIV_LAT;
            m_res_sel = 1'b0;
            m_pend    = 1'b0;
        end else begin
            if (m_done) m_active = 1'b0;
            if (m_done || flush) m_pend = 1'b0;
        end
        cyc++;
    end

    task automatic step(input bit v, input logic [2:0] op, input bit rd, input bit fl, input bit c);
        @(posedge clk);
        #1;
        clr = c; req_valid = v; req_op = op; rd_req = rd; flush = fl;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        int n;
        step(0, 3'd0, 0, 0, 1);
        chk_en = 1'b1;
        step(1, 3'd1, 1, 0, 1);
        chk("rst_mul_start", 8'(mul_start), 8'd0);
        chk("rst_stall", 8'(stall), 8'd0);
        step(0, 3'd0, 0, 0, 0);
        chk("rst_ready", 8'(req_ready), 8'd1);
        chk("rst_res_sel", 8'(res_sel), 8'd0);

        // MULT timing
        step(1, 3'd1, 0, 0, 0);
        chk("mult_t0_start", 8'(mul_start), 8'd1);
        chk("mult_t0_sign", 8'(core_sign), 8'd1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 3'd0, 0, 0, 0);
            chk("mult_busy", 8'(busy), 8'd1);
            chk("mult_res_sel", 8'(res_sel), 8'd1);
        end
        step(0, 3'd0, 0, 0, 0);
        chk("mult_t5_ready", 8'(req_ready), 8'd1);
        chk("mult_t5_busy", 8'(busy), 8'd0);
        idle(1);

        // DIVU then MFLO held
        step(1, 3'd4, 0, 0, 0);
        chk("divu_start", 8'(div_start), 8'd1);
        chk("divu_sign", 8'(core_sign), 8'd0);
        n = 0;
        for (int i = 1; i <= 32; i++) begin
            step(0, 3'd0, 1, 0, 0);
            if (stall) n++;
        end
        chk("divu_stall_cycles", 8'(n), 8'd32);
        step(0, 3'd0, 1, 0, 0);
        chk("divu_t33_stall", 8'(stall), 8'd0);
        chk("divu_t33_ready", 8'(req_ready), 8'd1);
        idle(1);

        // MUL then DIV in done cycle
        step(1, 3'd5, 0, 0, 0);
        idle(4);
        step(1, 3'd3, 0, 0, 0);
        chk("mul_div_wb", 8'(wb_valid), 8'd1);
        chk("mul_div_start", 8'(div_start), 8'd1);
        step(0, 3'd0, 0, 0, 0);
        chk("mul_div_res_sel", 8'(res_sel), 8'd0);
        chk("mul_div_busy", 8'(busy), 8'd1);
        idle(34);

        // MUL flushed at t2
        step(1, 3'd5, 0, 0, 0);
        idle(1);
        step(0, 3'd0, 0, 1, 0);
        idle(1);
        step(0, 3'd0, 0, 0, 0);
        chk("flush_t4_busy", 8'(busy), 8'd1);
        step(0, 3'd0, 0, 0, 0);
        chk("flush_t5_wb", 8'(wb_valid), 8'd0);
        chk("flush_t5_busy", 8'(busy), 8'd0);
        idle(1);

        // MTHI flushed, then MTHI behind a DIV
        step(1, 3'd6, 0, 1, 0);
        chk("mthi_flush_we", 8'(hilo_we), 8'd0);
        step(1, 3'd3, 0, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            step(1, 3'd6, 0, 0, 0);
            if (i == 1) chk("mthi_stall", 8'(stall), 8'd1);
        end
        step(1, 3'd6, 0, 0, 0);
        chk("mthi_done_we", 8'(hilo_we), 8'd2);
        chk("mthi_done_stall", 8'(stall), 8'd0);
        step(0, 3'd0, 0, 0, 0);
        chk("mthi_after_busy", 8'(busy), 8'd0);

        // Clr mid-DIV
        step(1, 3'd3, 0, 0, 0);
        idle(2);
        step(0, 3'd0, 0, 0, 1);
        chk("clr_t3_busy", 8'(busy), 8'd0);
        step(0, 3'd0, 0, 0, 0);
        chk("clr_t4_ready", 8'(req_ready), 8'd1);
        chk("clr_t4_busy", 8'(busy), 8'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 3'd0, 0, 0, 0);
            if (wb_valid) n++;
        end
        chk("clr_no_wb", 8'(n), 8'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0);
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
